// File: rtl/rr_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the round-robin memory arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface rr_mem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]          reqValid;
  logic [N_REQ-1:0]          reqWr;
  logic [N_REQ*ADDR_W-1:0]   reqAddr;
  logic [N_REQ*DATA_W-1:0]   reqWData;
  logic [N_REQ*DATA_W/8-1:0] reqWStrb;
  logic [N_REQ-1:0]          respReady;
  logic                      respErr;
  logic [DATA_W-1:0]         memDataOutReg;
  logic                      memReq;
  logic                      memWr;
  logic [ADDR_W-1:0]         memAddr;
  logic [DATA_W-1:0]         memDataIn;
  logic [DATA_W/8-1:0]       memWStrb;
  logic                      memDone;
  logic [DATA_W-1:0]         memDataOut;

  modport slave (
    input  reqValid, reqWr, reqAddr, reqWData, reqWStrb, memDone, memDataOut,
    output respReady, respErr, memDataOutReg, memReq, memWr, memAddr, memDataIn, memWStrb
  );

  modport master (
    output reqValid, reqWr, reqAddr, reqWData, reqWStrb, memDone, memDataOut,
    input  respReady, respErr, memDataOutReg, memReq, memWr, memAddr, memDataIn, memWStrb
  );
endinterface

// File: rtl/rr_mem_arbiter.sv
// N-requester round-robin arbiter for a single shared memory port, with byte-strobe
// writes, one-hot completion pulses and a response timeout that reports an error.
module rr_mem_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  rr_mem_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   SUM_WRAP = (PTR_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rrPtr_q;
  logic [PTR_W-1:0]   grantIdx_q;
  logic [PTR_W-1:0]   grantIdx_d;
  logic               grantValid_d;
  logic [PTR_W:0]     searchSum;
  logic [PTR_W-1:0]   searchIdx;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   respReady_q;
  logic               respErr_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               memReq_q;
  logic               memWr_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [DATA_W-1:0]  memDataIn_q;
  logic [STRB_W-1:0]  memWStrb_q;

  // Walk offsets from the far end down so the requester closest to rrPtr wins.
  always_comb begin
    grantValid_d = 1'b0;
    grantIdx_d   = rrPtr_q;
    searchSum    = '0;
    searchIdx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      searchSum = {1'b0, rrPtr_q} + (PTR_W + 1)'(k);
      if (searchSum >= SUM_WRAP) begin
        searchSum = searchSum - SUM_WRAP;
      end
      searchIdx = searchSum[PTR_W-1:0];
      if (bus.reqValid[searchIdx]) begin
        grantValid_d = 1'b1;
        grantIdx_d   = searchIdx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      grantIdx_q  <= '0;
      cnt_q       <= '0;
      respReady_q <= '0;
      respErr_q   <= 1'b0;
      rdata_q     <= '0;
      memReq_q    <= 1'b0;
      memWr_q     <= 1'b0;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
      memWStrb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid_d) begin
            memReq_q    <= 1'b1;
            memWr_q     <= bus.reqWr[grantIdx_d];
            memAddr_q   <= bus.reqAddr[int'(grantIdx_d) * ADDR_W +: ADDR_W];
            memDataIn_q <= bus.reqWData[int'(grantIdx_d) * DATA_W +: DATA_W];
            memWStrb_q  <= bus.reqWStrb[int'(grantIdx_d) * STRB_W +: STRB_W];
            grantIdx_q  <= grantIdx_d;
            rrPtr_q     <= (grantIdx_d == PTR_LAST) ? '0 : grantIdx_d + PTR_W'(1);
            cnt_q       <= '0;
            state_q     <= WAIT;
          end
        end
        // A real completion takes precedence over a timeout landing in the same cycle.
        WAIT: begin
          if (bus.memDone) begin
            rdata_q     <= bus.memDataOut;
            respReady_q <= ONE_HOT0 << grantIdx_q;
            respErr_q   <= 1'b0;
            memReq_q    <= 1'b0;
            state_q     <= RESP;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            rdata_q     <= '0;
            respReady_q <= ONE_HOT0 << grantIdx_q;
            respErr_q   <= 1'b1;
            memReq_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          respReady_q <= '0;
          respErr_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.respReady     = respReady_q;
  assign bus.respErr       = respErr_q;
  assign bus.memDataOutReg = rdata_q;
  assign bus.memReq        = memReq_q;
  assign bus.memWr         = memWr_q;
  assign bus.memAddr       = memAddr_q;
  assign bus.memDataIn     = memDataIn_q;
  assign bus.memWStrb      = memWStrb_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed bench for rr_mem_arbiter: a 2-requester instance (default timeout) and a
// 4-requester instance with TIMEOUT=4 share clock and reset.
module tb_rr_mem_arbiter;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  logic [31:0] addrB  [4];
  logic [31:0] wdataB [4];
  logic [3:0]  strbB  [4];

  rr_mem_arbiter_if #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) busA ();
  rr_mem_arbiter_if #(.N_REQ(4), .ADDR_W(32), .DATA_W(32)) busB ();

  rr_mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  rr_mem_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    busB.reqWr[i]            = wr;
    busB.reqAddr[i*32 +: 32] = addr;
    busB.reqWData[i*32 +: 32] = wdata;
    busB.reqWStrb[i*4 +: 4]  = strb;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    addrB[0] = 32'h040; wdataB[0] = 32'h12345678; strbB[0] = 4'b0011;
    addrB[1] = 32'h110; wdataB[1] = 32'hA0000001; strbB[1] = 4'hF;
    addrB[2] = 32'h200; wdataB[2] = 32'hA0000002; strbB[2] = 4'hF;
    addrB[3] = 32'h330; wdataB[3] = 32'hA0000003; strbB[3] = 4'hF;

    reset = 1'b1;
    busA.reqValid = '0; busA.reqWr = '0; busA.reqAddr = '0; busA.reqWData = '0;
    busA.reqWStrb = '0; busA.memDone = 1'b0; busA.memDataOut = '0;
    busB.reqValid = '0; busB.reqWr = '0; busB.reqAddr = '0; busB.reqWData = '0;
    busB.reqWStrb = '0; busB.memDone = 1'b0; busB.memDataOut = '0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, addrB[i], wdataB[i], strbB[i]);

    repeat (2) tick();
    $display("[TB] reset state");
    checkOutput("rst_memReq", busB.memReq, 0);
    checkOutput("rst_respReady", busB.respReady, 0);
    checkOutput("rst_memAddr", busB.memAddr, 0);
    reset = 1'b0;

    // Fairness: all four requesting, one memDone one cycle after each memReq rise
    $display("[TB] round-robin rotation");
    busB.reqValid = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      tick();
      checkOutput("rr_memReq", busB.memReq, 1);
      checkOutput("rr_memAddr", busB.memAddr, addrB[t % 4]);
      busB.memDone    = 1'b1;
      busB.memDataOut = 32'hC0DE0000 + t;
      tick();
      checkOutput("rr_respReady", busB.respReady, 4'b0001 << (t % 4));
      checkOutput("rr_respErr", busB.respErr, 0);
      checkOutput("rr_rdata", busB.memDataOutReg, 32'hC0DE0000 + t);
      checkOutput("rr_memReqLow", busB.memReq, 0);
      busB.memDone = 1'b0;
      tick();
    end
    busB.reqValid = '0;

    // Byte-strobe write from requester 0 (pointer now at 2, only 0 requesting)
    $display("[TB] strobed write");
    applyStimulus(0, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    busB.reqValid = 4'b0001;
    tick();
    checkOutput("wr_memReq", busB.memReq, 1);
    checkOutput("wr_memWr", busB.memWr, 1);
    checkOutput("wr_memAddr", busB.memAddr, 32'h40);
    checkOutput("wr_memDataIn", busB.memDataIn, 32'h12345678);
    checkOutput("wr_memWStrb", busB.memWStrb, 4'b0011);
    tick();
    checkOutput("wr_stableData", busB.memDataIn, 32'h12345678);
    checkOutput("wr_stableStrb", busB.memWStrb, 4'b0011);
    checkOutput("wr_noResp", busB.respReady, 0);
    busB.memDone    = 1'b1;
    busB.memDataOut = 32'h55AA55AA;
    tick();
    checkOutput("wr_respReady", busB.respReady, 4'b0001);
    checkOutput("wr_rdata", busB.memDataOutReg, 32'h55AA55AA);
    busB.memDone  = 1'b0;
    busB.reqValid = '0;
    applyStimulus(0, 1'b0, addrB[0], wdataB[0], strbB[0]);
    tick();
    tick();
    checkOutput("idle_memReq", busB.memReq, 0);
    checkOutput("idle_holdAddr", busB.memAddr, 32'h40);
    checkOutput("idle_holdRdata", busB.memDataOutReg, 32'h55AA55AA);

    // Timeout: pointer at 1, requesters 0,1,3 pending, memory never answers
    $display("[TB] timeout");
    busB.reqValid = 4'b1011;
    tick();
    checkOutput("to_memReq", busB.memReq, 1);
    checkOutput("to_memAddr", busB.memAddr, 32'h110);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("to_waitReq", busB.memReq, 1);
      checkOutput("to_waitResp", busB.respReady, 0);
    end
    tick();
    checkOutput("to_respReady", busB.respReady, 4'b0010);
    checkOutput("to_respErr", busB.respErr, 1);
    checkOutput("to_rdataZero", busB.memDataOutReg, 0);
    checkOutput("to_memReqLow", busB.memReq, 0);
    tick();
    checkOutput("to_respDrop", busB.respReady, 0);
    checkOutput("to_errDrop", busB.respErr, 0);

    // memDone lands on the same cycle the timeout would fire
    $display("[TB] memDone versus timeout");
    tick();
    checkOutput("tie_memAddr", busB.memAddr, 32'h330);
    tick();
    tick();
    tick();
    busB.memDone    = 1'b1;
    busB.memDataOut = 32'hA5A5A5A5;
    tick();
    checkOutput("tie_respReady", busB.respReady, 4'b1000);
    checkOutput("tie_respErr", busB.respErr, 0);
    checkOutput("tie_rdata", busB.memDataOutReg, 32'hA5A5A5A5);
    busB.memDone  = 1'b0;
    busB.reqValid = '0;
    tick();

    // Two-requester instance, read from requester 1
    $display("[TB] two-requester read");
    busA.reqAddr[32 +: 32] = 32'h100;
    busA.reqValid = 2'b10;
    tick();
    checkOutput("a_memReq", busA.memReq, 1);
    checkOutput("a_memAddr", busA.memAddr, 32'h100);
    checkOutput("a_memWr", busA.memWr, 0);
    tick();
    busA.memDone    = 1'b1;
    busA.memDataOut = 32'hDEADBEEF;
    tick();
    checkOutput("a_respReady", busA.respReady, 2'b10);
    checkOutput("a_rdata", busA.memDataOutReg, 32'hDEADBEEF);
    checkOutput("a_respErr", busA.respErr, 0);
    busA.memDone  = 1'b0;
    busA.reqValid = '0;
    tick();
    checkOutput("a_respPulse", busA.respReady, 0);

    // Reset in the middle of a WAIT, then a stray memDone right after release
    $display("[TB] reset mid-transaction");
    busB.reqValid = 4'b0100;
    tick();
    checkOutput("r_memAddr", busB.memAddr, 32'h200);
    tick();
    reset = 1'b1;
    busB.reqValid = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("r_memReq", busB.memReq, 0);
    checkOutput("r_memAddr0", busB.memAddr, 0);
    checkOutput("r_memDataIn0", busB.memDataIn, 0);
    checkOutput("r_memWStrb0", busB.memWStrb, 0);
    checkOutput("r_rdataA0", busA.memDataOutReg, 0);
    busB.memDone    = 1'b1;
    busB.memDataOut = 32'hFFFF0000;
    tick();
    checkOutput("r_strayResp", busB.respReady, 0);
    checkOutput("r_strayRdata", busB.memDataOutReg, 0);
    checkOutput("r_strayReq", busB.memReq, 0);
    busB.memDone  = 1'b0;
    busB.reqValid = 4'b1010;
    tick();
    checkOutput("r_grantFrom0", busB.memAddr, 32'h110);
    busB.memDone    = 1'b1;
    busB.memDataOut = 32'h0;
    tick();
    checkOutput("r_respReady", busB.respReady, 4'b0010);
    busB.memDone  = 1'b0;
    busB.reqValid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
Name: rr_mem_arbiter

Overview:
Parametrised N-requester memory arbiter. It is the successor to the fixed two-port instruction/data time-division arbiter in the arb/ directory. It grants the single shared memory port to one requester at a time using round-robin priority, so no requester starves. It adds byte-strobe writes, a per-requester one-hot response, and a response timeout with an error flag. It sits between the core/cache request ports and the memory controller.

Parameters:
N_REQ, 2, number of requesters; legal range 2..16.
ADDR_W, 32, address width.
DATA_W, 32, data width; must be a multiple of 8.
TIMEOUT, 255, maximum number of WAIT cycles before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
reqValid  in  N_REQ  per-requester request. A requester holds it high with stable fields until its respReady pulse.
reqWr  in  N_REQ  per-requester direction: 1 = write, 0 = read.
reqAddr  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
reqWData  in  N_REQ*DATA_W  flattened write data.
reqWStrb  in  N_REQ*(DATA_W/8)  flattened byte enables.
respReady  out  N_REQ  one-hot completion pulse, 1 cycle.
respErr  out  1  completion was caused by timeout; valid while respReady is nonzero.
memDataOutReg  out  DATA_W  registered read data; valid while respReady is nonzero.
memReq  out  1  memory request, level.
memWr  out  1  write enable to memory.
memAddr  out  ADDR_W  address to memory.
memDataIn  out  DATA_W  write data to memory.
memWStrb  out  DATA_W/8  byte enables to memory.
memDone  in  1  memory completion pulse; counted only while memReq=1.
memDataOut  in  DATA_W  read data from memory; valid with memDone.

Behaviour:
- Reset: every output = 0; state = IDLE; rrPtr = 0; timeout counter = 0. Reset takes effect at the next edge in any state. An in-flight transaction is abandoned, and memDone arriving after reset is ignored.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If reqValid != 0, grant g = the first i with reqValid[i]=1, searching rrPtr, rrPtr+1, … and wrapping modulo N_REQ.
  - At the edge: latch g's addr/wr/wdata/strb into memAddr/memWr/memDataIn/memWStrb; memReq <= 1; rrPtr <= (g+1) mod N_REQ; counter <= 0; state -> WAIT.
  - If reqValid == 0: stay in IDLE; memReq stays 0; memAddr and the other mem outputs hold their last values.
- WAIT:
  - memReq and all mem outputs are held stable.
  - If memDone=1: memDataOutReg <= memDataOut (also captured on writes); respReady <= 1<<g; respErr <= 0; memReq <= 0; state -> RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: memDataOutReg <= 0; respReady <= 1<<g; respErr <= 1; memReq <= 0; state -> RESP.
  - Else: counter += 1.
  - If memDone and timeout occur in the same cycle, memDone wins.
- RESP:
  - respReady/respErr/memDataOutReg are visible for exactly this cycle.
  - At the edge: respReady <= 0; respErr <= 0; state -> IDLE.
  - reqValid is not sampled in RESP, so the just-served requester has a cycle to drop or update its request.
- Latency: reqValid sampled in IDLE at cycle 0 -> memReq high from cycle 1 -> memDone at cycle k (k >= 1) -> respReady at cycle k+1 -> IDLE at k+2. Back-to-back throughput is one transaction per (k+2) cycles.
- Fairness: with all N_REQ requesters permanently requesting, grants rotate 0,1,…,N_REQ-1,0…
- memDone while memReq=0 (IDLE/RESP) is ignored.
- reqValid dropping during WAIT does not cancel the transaction; it completes and pulses respReady normally.
- memDataOutReg holds its value outside RESP. respErr is 0 whenever respReady=0.
- Counter width = clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
1. Assert reset for 2 cycles mid-WAIT, then fire memDone 1 cycle after release -> every output 0, memDone ignored, next grant starts search at requester 0.
2. N_REQ=2: reqValid=2'b10, reqAddr[1]=0x100, reqWr=0; memDone with memDataOut=0xDEADBEEF on the 2nd WAIT cycle -> memReq=1 with memAddr=0x100, memWr=0; then respReady=2'b10, memDataOutReg=0xDEADBEEF, respErr=0 for 1 cycle.
3. N_REQ=4: reqValid=4'b1111 held, memDone 1 cycle after each memReq rise -> memAddr sequence follows requesters 0,1,2,3,0,1; respReady one-hot matches each grant.
4. Write from requester 0: addr 0x40, data 0x12345678, strb 4'b0011 -> memWr=1, memDataIn=0x12345678, memWStrb=4'b0011, stable until memDone; respReady=4'b0001.
5. TIMEOUT=4, memDone never asserted -> respReady for the granted requester exactly 4 WAIT cycles after memReq rise; respErr=1, memDataOutReg=0; memReq=0 in RESP; next grant goes to the following requester.
6. memDone coincident with the timeout cycle (TIMEOUT=4, memDone in the 4th WAIT cycle, memDataOut=0xA5A5A5A5) -> respErr=0, memDataOutReg=0xA5A5A5A5.
